instruction_fetch: RTL and testbench

Fetch-side initiator for the synchronous instruction memory: owns the program counter, drives `read_addr`, captures the returned `instruction` one cycle later, and presents a registered IF/ID bundle (`if_valid`, `if_pc`, `if_instr`) to decode. Supports pipeline stall (hold) and taken-branch/jump redirect (flush of the in-flight read). It sits between the control/branch logic and `instruction_memory`, whose read data for the address sampled at posedge N is valid throughout the cycle after N.

---
 rtl/instruction_fetch.sv | 65 ++++++
 tb/tb_instruction_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues addresses to a synchronous instruction memory
// and registers the returned word into the IF/ID bundle, with stall and redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] read_addr,
  input  logic [31:0] instruction,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
);

  // state | meaning
  // FILL   | no valid read in flight (after reset or redirect)
  // STREAM | the address sampled at the last edge is a real fetch
  typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inflight_pc_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        hold;

  assign hold = stall && !redirect_valid;

  // While held, re-present the in-flight address so the memory data stays put.
  assign read_addr   = hold ? inflight_pc_q : pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0000_0000;
      if_instr_q    <= 32'h0000_0000;
    end else if (redirect_valid) begin
      // The read issued at this edge is wrong-path; FILL marks it as discarded.
      state_q       <= FILL;
      pc_q          <= redirect_pc & 32'hFFFF_FFFC;
      inflight_pc_q <= pc_q;
      if_valid_q    <= 1'b0;
    end else if (!stall) begin
      state_q       <= STREAM;
      pc_q          <= pc_q + 32'd4;
      inflight_pc_q <= pc_q;
      if_valid_q    <= (state_q == STREAM);
      if_pc_q       <= inflight_pc_q;
      if_instr_q    <= instruction;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances (RESET_PC 0 and 0x100)
// share stimulus, each backed by its own registered instruction memory model.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] ra0, instr0, pc0, ins0, p40;
  logic        v0;
  logic [31:0] ra1, instr1, pc1, ins1, p41;
  logic        v1;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .read_addr(ra0), .instruction(instr0),
    .if_valid(v0), .if_pc(pc0), .if_instr(ins0), .if_pc_plus4(p40)
  );

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .read_addr(ra1), .instruction(instr1),
    .if_valid(v1), .if_pc(pc1), .if_instr(ins1), .if_pc_plus4(p41)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    instr0 <= 32'h1000_0000 + {24'h0, ra0[9:2]};
    instr1 <= 32'h1000_0000 + {24'h0, ra1[9:2]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    checks++;
    if ({v0, pc0, ins0, ra0} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state0: got v=%0b pc=%h ins=%h ra=%h want 0/0/0/0", v0, pc0, ins0, ra0);
    end
    checks++;
    if ({v1, pc1, ra1} !== {1'b0, 32'h0, 32'h100}) begin
      errors++;
      $display("FAIL reset_state1: got v=%0b pc=%h ra=%h want 0/0/00000100", v1, pc1, ra1);
    end
    stall = 1'b1;
    #1;
    checks++;
    if (ra0 !== 32'h0) begin
      errors++; $display("FAIL reset_ra_stall: got %h want 00000000", ra0);
    end
    stall = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (ra0 !== 32'h0) begin
      errors++; $display("FAIL release_ra0: got %h want 00000000", ra0);
    end
    step(); // edge 1
    checks++;
    if ({v0, ra0} !== {1'b0, 32'h4}) begin
      errors++; $display("FAIL edge1: got v=%0b ra=%h want v=0 ra=00000004", v0, ra0);
    end
    step(); // edge 2
    checks++;
    if ({v0, pc0, ins0, ra0} !== {1'b1, 32'h0, 32'h1000_0000, 32'h8}) begin
      errors++;
      $display("FAIL edge2: got v=%0b pc=%h ins=%h ra=%h want 1/00000000/10000000/00000008", v0, pc0, ins0, ra0);
    end
    step(); // edge 3
    checks++;
    if ({v0, pc0, ins0, p40, ra0} !== {1'b1, 32'h4, 32'h1000_0001, 32'h8, 32'hC}) begin
      errors++;
      $display("FAIL edge3: got v=%0b pc=%h ins=%h p4=%h ra=%h want 1/4/10000001/8/c", v0, pc0, ins0, p40, ra0);
    end
  endtask

  task automatic test_stall();
    step(); // if_pc becomes 8
    checks++;
    if ({pc0, ins0} !== {32'h8, 32'h1000_0002}) begin
      errors++; $display("FAIL pre_stall: got pc=%h ins=%h want 8/10000002", pc0, ins0);
    end
    stall = 1'b1;
    #1;
    checks++;
    if (ra0 !== 32'hC) begin
      errors++; $display("FAIL stall_ra_comb: got %h want 0000000c", ra0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({v0, pc0, ins0, ra0} !== {1'b1, 32'h8, 32'h1000_0002, 32'hC}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%h ins=%h ra=%h want 1/8/10000002/c", i, v0, pc0, ins0, ra0);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if ({v0, pc0, ins0} !== {1'b1, 32'hC, 32'h1000_0003}) begin
      errors++; $display("FAIL stall_release: got v=%0b pc=%h ins=%h want 1/c/10000003", v0, pc0, ins0);
    end
    step();
    checks++;
    if ({pc0, ins0} !== {32'h10, 32'h1000_0004}) begin
      errors++; $display("FAIL stall_after: got pc=%h ins=%h want 10/10000004", pc0, ins0);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    checks++;
    if ({v0, ra0} !== {1'b0, 32'h40}) begin
      errors++; $display("FAIL redir_r: got v=%0b ra=%h want 0/40", v0, ra0);
    end
    step();
    checks++;
    if (v0 !== 1'b0) begin
      errors++; $display("FAIL redir_r1: got v=%0b want 0", v0);
    end
    step();
    checks++;
    if ({v0, pc0, ins0} !== {1'b1, 32'h40, 32'h1000_0010}) begin
      errors++; $display("FAIL redir_r2: got v=%0b pc=%h ins=%h want 1/40/10000010", v0, pc0, ins0);
    end
    step();
    checks++;
    if ({v0, pc0, ins0} !== {1'b1, 32'h44, 32'h1000_0011}) begin
      errors++; $display("FAIL redir_r3: got v=%0b pc=%h ins=%h want 1/44/10000011", v0, pc0, ins0);
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    checks++;
    if ({v0, ra0} !== {1'b0, 32'h40}) begin
      errors++; $display("FAIL rs_taken: got v=%0b ra=%h want 0/40", v0, ra0);
    end
    step();
    checks++;
    if ({v0, ra0} !== {1'b0, 32'h44}) begin
      errors++; $display("FAIL rs_r1: got v=%0b ra=%h want 0/44", v0, ra0);
    end
    step();
    checks++;
    if ({v0, pc0, ins0, ra0[1:0]} !== {1'b1, 32'h40, 32'h1000_0010, 2'b00}) begin
      errors++; $display("FAIL rs_r2: got v=%0b pc=%h ins=%h ra=%h want 1/40/10000010 aligned", v0, pc0, ins0, ra0);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    checks++;
    if ({v0, pc0, ins0, p40} !== {1'b1, 32'hFFFF_FFF8, 32'h1000_00FE, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap0: got v=%0b pc=%h ins=%h p4=%h want 1/fffffff8/100000fe/fffffffc", v0, pc0, ins0, p40);
    end
    step();
    checks++;
    if ({pc0, ins0, p40} !== {32'hFFFF_FFFC, 32'h1000_00FF, 32'h0}) begin
      errors++; $display("FAIL wrap1: got pc=%h ins=%h p4=%h want fffffffc/100000ff/0", pc0, ins0, p40);
    end
    step();
    checks++;
    if ({v0, pc0, ins0} !== {1'b1, 32'h0, 32'h1000_0000}) begin
      errors++; $display("FAIL wrap2: got v=%0b pc=%h ins=%h want 1/0/10000000", v0, pc0, ins0);
    end
  endtask

  task automatic test_async_reset();
    step();
    checks++;
    if (v1 !== 1'b1) begin
      errors++; $display("FAIL ar_streaming: got v1=%0b want 1", v1);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({v1, pc1, ra1} !== {1'b0, 32'h0, 32'h100}) begin
      errors++; $display("FAIL ar_immediate: got v=%0b pc=%h ra=%h want 0/0/100", v1, pc1, ra1);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({v1, ra1} !== {1'b0, 32'h104}) begin
      errors++; $display("FAIL ar_edge1: got v=%0b ra=%h want 0/104", v1, ra1);
    end
    step();
    checks++;
    if ({v1, pc1, ins1} !== {1'b1, 32'h100, 32'h1000_0040}) begin
      errors++; $display("FAIL ar_edge2: got v=%0b pc=%h ins=%h want 1/100/10000040", v1, pc1, ins1);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
